cam_dvp_tx: RTL and testbench

- Camera-side DVP transmitter: the other end of the OV7670-style parallel camera capture interface (pclk / vsync / href / 8-bit data).
- Takes RGB565 pixels from a ready/valid source and emits the frame as a byte stream with OV7670-compatible sync timing.
- Used as a camera emulator for loopback and bench testing of the capture + grayscale + buffer path, without the physical sensor.

---
 rtl/cam_dvp_pkg.sv | 49 ++++
 rtl/dvp_timing_gen.sv | 134 +++++++++++++
 rtl/cam_dvp_tx.sv | 134 +++++++++++++
 tb/tb_cam_dvp_tx.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_dvp_pkg.sv
// Shared types and constants for the DVP camera-emulator transmitter.
package cam_dvp_pkg;

  // Frame-level sequencing state
  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVback,
    StActive,
    StVfront
  } dvp_state_e;

  // Default OV7670 VGA timing
  localparam int unsigned DefHActive    = 640;
  localparam int unsigned DefHBlank     = 144;
  localparam int unsigned DefVActive    = 480;
  localparam int unsigned DefVsyncLines = 3;
  localparam int unsigned DefVBack      = 17;
  localparam int unsigned DefVFront     = 10;

  // RGB565 goes out high byte first
  localparam bit HiByteFirst = 1'b1;

  // RGB565 colour bars, left to right
  localparam logic [15:0] BarWhite   = 16'hFFFF;
  localparam logic [15:0] BarYellow  = 16'hFFE0;
  localparam logic [15:0] BarCyan    = 16'h07FF;
  localparam logic [15:0] BarGreen   = 16'h07E0;
  localparam logic [15:0] BarMagenta = 16'hF81F;
  localparam logic [15:0] BarRed     = 16'hF800;
  localparam logic [15:0] BarBlue    = 16'h001F;
  localparam logic [15:0] BarBlack   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0: c = BarWhite;
      3'd1: c = BarYellow;
      3'd2: c = BarCyan;
      3'd3: c = BarGreen;
      3'd4: c = BarMagenta;
      3'd5: c = BarRed;
      3'd6: c = BarBlue;
      3'd7: c = BarBlack;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// DVP sync timing: byte phase, byte/line counters and frame state machine.
// state/byte/line describe the byte that starts at the next phase 1->0 edge;
// the sync outputs are registered at that edge so they hold across tx_pclk rise.
module dvp_timing_gen
  import cam_dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter int unsigned H_BLANK     = DefHBlank,
  parameter int unsigned V_ACTIVE    = DefVActive,
  parameter int unsigned VSYNC_LINES = DefVsyncLines,
  parameter int unsigned V_BACK      = DefVBack,
  parameter int unsigned V_FRONT     = DefVFront
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        enable,
  output logic        tx_pclk,
  output logic        tx_vsync,
  output logic        tx_href,
  output logic        byte_edge,
  output logic        fetch,
  output logic        send_lo,
  output logic        vsync_rise,
  output logic        frame_done,
  output logic [10:0] pix_x
);

  localparam logic [10:0] LastByte = 11'(2 * (H_ACTIVE + H_BLANK) - 1);
  localparam logic [10:0] ActEnd   = 11'(2 * H_ACTIVE);

  dvp_state_e  state_q, state_d;
  logic        phase_q, phase_d;
  logic [10:0] byte_q, byte_d;
  logic [9:0]  line_q, line_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic        done_q, done_d;
  logic [9:0]  last_line_idx;
  logic        last_byte, last_line, in_act;

  // Index of the final line of the current state
  always_comb begin
    last_line_idx = '0;
    unique case (state_q)
      StVsync:  last_line_idx = 10'(VSYNC_LINES - 1);
      StVback:  last_line_idx = 10'(V_BACK - 1);
      StActive: last_line_idx = 10'(V_ACTIVE - 1);
      StVfront: last_line_idx = 10'(V_FRONT - 1);
      default:  last_line_idx = '0;
    endcase
  end

  assign last_byte = (byte_q == LastByte);
  assign last_line = (line_q == last_line_idx);
  assign in_act    = (state_q == StActive) && (byte_q < ActEnd);

  // State, counters and registered sync outputs
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= 1'b0;
      byte_q  <= '0;
      line_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      done_q  <= done_d;
    end
  end

  // Next-state: advance position once per byte period
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    byte_d  = byte_q;
    line_d  = line_q;
    if (state_q == StIdle) begin
      phase_d = 1'b0;
      byte_d  = '0;
      line_d  = '0;
      if (enable) state_d = StVsync;
    end else begin
      phase_d = ~phase_q;
      if (byte_edge) begin
        if (last_byte) begin
          byte_d = '0;
          if (last_line) begin
            line_d = '0;
            unique case (state_q)
              StVsync:  state_d = StVback;
              StVback:  state_d = StActive;
              StActive: state_d = StVfront;
              StVfront: state_d = enable ? StVsync : StIdle;
              default:  state_d = StIdle;
            endcase
          end else begin
            line_d = line_q + 10'd1;
          end
        end else begin
          byte_d = byte_q + 11'd1;
        end
      end
    end
  end

  // Outputs: strobes for the byte about to start, next values of sync regs
  always_comb begin
    byte_edge  = (state_q != StIdle) && phase_q;
    fetch      = byte_edge && in_act && !byte_q[0];
    send_lo    = byte_edge && in_act && byte_q[0];
    vsync_rise = byte_edge && (state_q == StVsync) && (byte_q == '0) && (line_q == '0);
    vsync_d    = vsync_q;
    href_d     = href_q;
    if (byte_edge) begin
      vsync_d = (state_q == StVsync);
      href_d  = in_act;
    end
    done_d = byte_edge && (state_q == StVfront) && last_byte && last_line;
  end

  assign tx_pclk    = phase_q;
  assign tx_vsync   = vsync_q;
  assign tx_href    = href_q;
  assign frame_done = done_q;
  assign pix_x      = {1'b0, byte_q[10:1]};

endmodule

// File: rtl/cam_dvp_tx.sv
// Camera-side DVP transmitter: RGB565 ready/valid in, OV7670-style byte stream out.
// Optional build macro CAM_DVP_TX_PATTERN_EN adds an internal colour-bar source.
module cam_dvp_tx
  import cam_dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter int unsigned H_BLANK     = DefHBlank,
  parameter int unsigned V_ACTIVE    = DefVActive,
  parameter int unsigned VSYNC_LINES = DefVsyncLines,
  parameter int unsigned V_BACK      = DefVBack,
  parameter int unsigned V_FRONT     = DefVFront
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        tx_pclk,
  output logic        tx_vsync,
  output logic        tx_href,
  output logic [7:0]  tx_data,
  output logic        frame_done,
  output logic        underrun,
`ifdef CAM_DVP_TX_PATTERN_EN
  input  logic        pattern_sel,
`endif
  input  logic        underrun_clr
);

  logic        byte_edge, fetch, send_lo, vsync_rise;
  logic [10:0] pix_x;
  logic        use_pat;
  logic [15:0] pixel;
  logic [7:0]  first_byte, second_byte;
  logic [7:0]  data_q, lo_q;
  logic        underrun_q;

  dvp_timing_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .H_BLANK     (H_BLANK),
    .V_ACTIVE    (V_ACTIVE),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) u_timing (
    .clk_25     (clk_25),
    .reset      (reset),
    .enable     (enable),
    .tx_pclk    (tx_pclk),
    .tx_vsync   (tx_vsync),
    .tx_href    (tx_href),
    .byte_edge  (byte_edge),
    .fetch      (fetch),
    .send_lo    (send_lo),
    .vsync_rise (vsync_rise),
    .frame_done (frame_done),
    .pix_x      (pix_x)
  );

`ifdef CAM_DVP_TX_PATTERN_EN
  logic        pat_q;
  int unsigned bar_calc;

  // Pattern selection latched once per frame so a frame is never mixed
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      pat_q <= 1'b0;
    end else if (vsync_rise) begin
      pat_q <= pattern_sel;
    end
  end

  assign use_pat  = pat_q;
  assign bar_calc = (32'(pix_x) * 32'd8) / H_ACTIVE;

  // Pixel source: colour bars or upstream, zero on underrun
  always_comb begin
    pixel = 16'h0000;
    if (use_pat) begin
      pixel = bar_color(3'(bar_calc));
    end else if (pix_valid) begin
      pixel = pix_data;
    end
  end
`else
  logic unused_pat_inputs;

  assign use_pat           = 1'b0;
  assign unused_pat_inputs = ^{vsync_rise, pix_x};

  // Pixel source: upstream, zero on underrun
  always_comb begin
    pixel = 16'h0000;
    if (pix_valid) begin
      pixel = pix_data;
    end
  end
`endif

  assign pix_ready   = fetch && !use_pat;
  assign first_byte  = HiByteFirst ? pixel[15:8] : pixel[7:0];
  assign second_byte = HiByteFirst ? pixel[7:0] : pixel[15:8];

  // Byte mux: first byte on fetch, held second byte next, zero in blanking
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      data_q <= 8'h00;
      lo_q   <= 8'h00;
    end else if (fetch) begin
      data_q <= first_byte;
      lo_q   <= second_byte;
    end else if (send_lo) begin
      data_q <= lo_q;
    end else if (byte_edge) begin
      data_q <= 8'h00;
    end
  end

  // Sticky underrun; a new underrun beats a simultaneous clear
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      underrun_q <= 1'b0;
    end else if (pix_ready && !pix_valid) begin
      underrun_q <= 1'b1;
    end else if (underrun_clr) begin
      underrun_q <= 1'b0;
    end
  end

  assign tx_data  = data_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Directed self-checking bench for cam_dvp_tx with a tiny 4x2 frame.
module tb_cam_dvp_tx;

  logic        clk_25 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] pix_data = 16'hA55A;
  logic        pix_valid = 1'b1;
  logic        underrun_clr = 1'b0;
  logic        pix_ready, tx_pclk, tx_vsync, tx_href, frame_done, underrun;
  logic [7:0]  tx_data;

  int errors = 0;
  int checks = 0;
  int src_idx = 0;

  logic [15:0] src_tbl [4] = '{16'hA55A, 16'h1234, 16'hBEEF, 16'h00FF};
  logic [7:0]  exp_line [8] = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'hBE, 8'hEF, 8'h00, 8'hFF};
  logic [7:0]  exp_under [8] = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'hFF};
  logic [7:0]  bytes_q [$];

  always #5 clk_25 = ~clk_25;

  cam_dvp_tx #(
    .H_ACTIVE    (4),
    .H_BLANK     (2),
    .V_ACTIVE    (2),
    .VSYNC_LINES (1),
    .V_BACK      (1),
    .V_FRONT     (1)
  ) dut (
    .clk_25       (clk_25),
    .reset        (reset),
    .enable       (enable),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .tx_pclk      (tx_pclk),
    .tx_vsync     (tx_vsync),
    .tx_href      (tx_href),
    .tx_data      (tx_data),
    .frame_done   (frame_done),
    .underrun     (underrun),
`ifdef CAM_DVP_TX_PATTERN_EN
    .pattern_sel  (1'b0),
`endif
    .underrun_clr (underrun_clr)
  );

  // Source: present the next table entry after each fetch edge
  always @(posedge clk_25) begin
    if (pix_ready === 1'b1) begin
      #1;
      src_idx = src_idx + 1;
      pix_data = src_tbl[src_idx % 4];
    end
  end

  // Receiver: capture active bytes on tx_pclk rise
  always @(posedge tx_pclk) begin
    if (tx_href === 1'b1) bytes_q.push_back(tx_data);
  end

  task automatic step();
    @(posedge clk_25);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    pix_valid = 1'b1;
    underrun_clr = 1'b0;
    src_idx = 0;
    pix_data = src_tbl[0];
    repeat (3) step();
    bytes_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({tx_pclk, tx_vsync, tx_href, tx_data, pix_ready, frame_done, underrun} !== 14'd0) begin
        errors++;
        $display("FAIL reset_outs cyc=%0d got pclk=%b vs=%b href=%b data=%h rdy=%b fd=%b ur=%b want all 0",
                 i, tx_pclk, tx_vsync, tx_href, tx_data, pix_ready, frame_done, underrun);
      end
    end
  endtask

  task automatic test_stream();
    int fetch_cyc = -1;
    int vs_run = 0, vs_first = 0;
    int run = 0, hi_first = 0, lo_first = 0;
    logic prev_href = 1'b0, prev_fd = 1'b0;
    int fd0 = -1, fd1 = -1, rises_f1 = 0, rises_f2 = 0, ready_f1 = 0, dbl = 0;
    do_reset();
    enable = 1'b1;
    #2 reset = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (fetch_cyc >= 0 && c == fetch_cyc + 1) begin
        checks++;
        if (tx_data !== 8'hA5 || tx_href !== 1'b1) begin
          errors++;
          $display("FAIL fetch_latency got data=%h href=%b want data=a5 href=1", tx_data, tx_href);
        end
      end
      if (pix_ready === 1'b1 && fetch_cyc < 0) fetch_cyc = c;
      if (tx_vsync === 1'b1) vs_run++;
      else if (vs_run > 0 && vs_first == 0) vs_first = vs_run;
      if (tx_href !== prev_href) begin
        if (prev_href && hi_first == 0) hi_first = run;
        if (!prev_href && hi_first != 0 && lo_first == 0) lo_first = run;
        if (tx_href === 1'b1) begin
          if (fd0 < 0) rises_f1++;
          else if (fd1 < 0) rises_f2++;
        end
        run = 1;
      end else begin
        run++;
      end
      prev_href = tx_href;
      if (fd0 < 0 && pix_ready === 1'b1) ready_f1++;
      if (frame_done === 1'b1) begin
        if (prev_fd) dbl++;
        if (fd0 < 0) fd0 = c;
        else if (fd1 < 0) fd1 = c;
      end
      prev_fd = frame_done;
    end
    checks++;
    if (vs_first != 24) begin
      errors++;
      $display("FAIL vsync_width got %0d want 24", vs_first);
    end
    checks++;
    if (hi_first != 16) begin
      errors++;
      $display("FAIL href_high got %0d want 16", hi_first);
    end
    checks++;
    if (lo_first != 8) begin
      errors++;
      $display("FAIL href_low got %0d want 8", lo_first);
    end
    checks++;
    if (fd0 < 0 || fd1 < 0 || fd1 - fd0 != 120) begin
      errors++;
      $display("FAIL frame_period got fd0=%0d fd1=%0d want spacing 120", fd0, fd1);
    end
    checks++;
    if (dbl != 0) begin
      errors++;
      $display("FAIL frame_done_width got %0d double pulses want 0", dbl);
    end
    checks++;
    if (rises_f1 != 2 || rises_f2 != 2) begin
      errors++;
      $display("FAIL active_lines got %0d,%0d want 2,2", rises_f1, rises_f2);
    end
    checks++;
    if (ready_f1 != 8) begin
      errors++;
      $display("FAIL ready_pulses got %0d want 8", ready_f1);
    end
    checks++;
    if (bytes_q.size() < 16) begin
      errors++;
      $display("FAIL byte_count got %0d want >=16", bytes_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (bytes_q[i] !== exp_line[i % 8]) begin
          errors++;
          $display("FAIL stream_byte[%0d] got %h want %h", i, bytes_q[i], exp_line[i % 8]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    int nf = 0;
    bit found = 1'b0;
    do_reset();
    enable = 1'b1;
    #2 reset = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      if (pix_ready === 1'b1) begin
        nf++;
        if (nf == 3) begin
          found = 1'b1;
          checks++;
          if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_pre got %b want 0", underrun);
          end
          pix_valid = 1'b0;
          step();
          pix_valid = 1'b1;
          checks++;
          if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set got %b want 1", underrun);
          end
        end
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL underrun_fetch got no 3rd fetch want one within 200 clk");
    end
    repeat (20) step();
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky got %b want 1", underrun);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= bytes_q.size() || bytes_q[i] !== exp_under[i]) begin
        errors++;
        $display("FAIL underrun_byte[%0d] got %h want %h", i,
                 (i < bytes_q.size()) ? bytes_q[i] : 8'hxx, exp_under[i]);
      end
    end
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear got %b want 0", underrun);
    end
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      if (pix_ready === 1'b1) begin
        found = 1'b1;
        pix_valid = 1'b0;
        underrun_clr = 1'b1;
        step();
        pix_valid = 1'b1;
        checks++;
        if (underrun !== 1'b1) begin
          errors++;
          $display("FAIL set_beats_clear got %b want 1", underrun);
        end
        step();
        underrun_clr = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
          errors++;
          $display("FAIL clear_after_set got %b want 0", underrun);
        end
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL set_clear_fetch got no fetch want one within 200 clk");
    end
  endtask

  task automatic test_enable_drop();
    bit found = 1'b0;
    int rises = 0, pclk_hi = 0, vs_hi = 0, fd_cnt = 0, href_hi = 0;
    logic prev_href = 1'b0;
    do_reset();
    enable = 1'b1;
    #2 reset = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      if (tx_href === 1'b1) found = 1'b1;
    end
    enable = 1'b0;
    rises = found ? 1 : 0;
    prev_href = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      if (tx_href === 1'b1 && !prev_href) rises++;
      prev_href = tx_href;
      if (frame_done === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || rises != 2) begin
      errors++;
      $display("FAIL drop_frame_complete got done=%b lines=%0d want done=1 lines=2", found, rises);
    end
    for (int c = 0; c < 150; c++) begin
      step();
      if (tx_pclk === 1'b1) pclk_hi++;
      if (tx_vsync === 1'b1) vs_hi++;
      if (frame_done === 1'b1) fd_cnt++;
      if (tx_href === 1'b1) href_hi++;
    end
    checks++;
    if (pclk_hi != 0 || vs_hi != 0 || fd_cnt != 0 || href_hi != 0) begin
      errors++;
      $display("FAIL drop_idle got pclk=%0d vsync=%0d fd=%0d href=%0d want all 0",
               pclk_hi, vs_hi, fd_cnt, href_hi);
    end
  endtask

  task automatic test_reset_midline();
    bit found = 1'b0;
    int gap = -1;
    do_reset();
    enable = 1'b1;
    #2 reset = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      if (tx_href === 1'b1) found = 1'b1;
    end
    repeat (3) step();
    checks++;
    if (tx_href !== 1'b1) begin
      errors++;
      $display("FAIL midline_setup got href=%b want 1", tx_href);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({tx_pclk, tx_vsync, tx_href, tx_data, pix_ready, frame_done, underrun} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset got pclk=%b vs=%b href=%b data=%h rdy=%b want all 0",
               tx_pclk, tx_vsync, tx_href, tx_data, pix_ready);
    end
    repeat (2) step();
    src_idx = 0;
    pix_data = src_tbl[0];
    bytes_q.delete();
    #2 reset = 1'b0;
    step();
    step();
    checks++;
    if (tx_vsync !== 1'b0 || tx_pclk !== 1'b1 || tx_href !== 1'b0) begin
      errors++;
      $display("FAIL restart_pre got vs=%b pclk=%b href=%b want 0,1,0", tx_vsync, tx_pclk, tx_href);
    end
    step();
    checks++;
    if (tx_vsync !== 1'b1 || tx_href !== 1'b0) begin
      errors++;
      $display("FAIL restart_vsync got vs=%b href=%b want 1,0", tx_vsync, tx_href);
    end
    for (int c = 1; c <= 100 && gap < 0; c++) begin
      step();
      if (tx_href === 1'b1) gap = c;
    end
    checks++;
    if (gap != 48) begin
      errors++;
      $display("FAIL restart_first_href got %0d clk want 48", gap);
    end
    repeat (30) step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= bytes_q.size() || bytes_q[i] !== exp_line[i]) begin
        errors++;
        $display("FAIL restart_byte[%0d] got %h want %h", i,
                 (i < bytes_q.size()) ? bytes_q[i] : 8'hxx, exp_line[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underrun();
    test_enable_drop();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
